// File: rtl/enc_arb_pkg.sv
// Shared types and constants for the encoder block arbiter.
// Holds the FSM state encoding, the default block length and a saturating counter helper.
package enc_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  localparam int BLOCK_LEN_DEFAULT = 255;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/enc_arb_rr.sv
// Two-way source pick: fixed priority to source 0, or round-robin away from the last grant.
module enc_arb_rr (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       fixed_prio_i,
  output logic       grant_o
);

  always_comb begin
    grant_o = 1'b0;
    if (req_i == 2'b11) begin
      grant_o = fixed_prio_i ? 1'b0 : ~last_grant_i;
    end else begin
      grant_o = req_i[1] & ~req_i[0];
    end
  end

endmodule

// File: rtl/enc_block_arbiter.sv
// Arbitrates two byte streams into fixed-length blocks for the convolutional encoder,
// trimming overlong blocks, flagging short ones and counting completed blocks per source.
module enc_block_arbiter
  import enc_arb_pkg::*;
#(
  parameter int BLOCK_LEN  = BLOCK_LEN_DEFAULT,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        s0_axis_valid,
  output logic        s0_axis_ready,
  input  logic [7:0]  s0_axis_data,
  input  logic        s0_axis_last,
  input  logic        s0_axis_is_parity,
  input  logic        s1_axis_valid,
  output logic        s1_axis_ready,
  input  logic [7:0]  s1_axis_data,
  input  logic        s1_axis_last,
  input  logic        s1_axis_is_parity,
  output logic        m_axis_valid,
  input  logic        m_axis_ready,
  output logic [7:0]  m_axis_data,
  output logic        m_axis_last,
  output logic        m_axis_sop,
  output logic        m_axis_is_parity,
  output logic        m_axis_src,
  output logic [15:0] blk_cnt0,
  output logic [15:0] blk_cnt1,
  output logic        len_err
);

  localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLOCK_LEN - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [15:0]      blk_cnt0_q, blk_cnt0_d;
  logic [15:0]      blk_cnt1_q, blk_cnt1_d;
  logic             len_err_q, len_err_d;

  logic             pick;
  logic             sel_valid, sel_last, sel_parity, sel_ready;
  logic [7:0]       sel_data;
  logic             at_max;

  enc_arb_rr u_rr (
    .req_i        ({s1_axis_valid, s0_axis_valid}),
    .last_grant_i (last_grant_q),
    .fixed_prio_i (FIXED_PRIO),
    .grant_o      (pick)
  );

  always_comb begin
    sel_valid  = grant_q ? s1_axis_valid     : s0_axis_valid;
    sel_data   = grant_q ? s1_axis_data      : s0_axis_data;
    sel_last   = grant_q ? s1_axis_last      : s0_axis_last;
    sel_parity = grant_q ? s1_axis_is_parity : s0_axis_is_parity;
    at_max     = (cnt_q == CNT_MAX);

    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    blk_cnt0_d   = blk_cnt0_q;
    blk_cnt1_d   = blk_cnt1_q;
    len_err_d    = 1'b0;

    sel_ready        = 1'b0;
    m_axis_valid     = 1'b0;
    m_axis_data      = 8'h00;
    m_axis_last      = 1'b0;
    m_axis_sop       = 1'b0;
    m_axis_is_parity = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && (s0_axis_valid || s1_axis_valid)) begin
          grant_d      = pick;
          last_grant_d = pick;
          cnt_d        = '0;
          state_d      = ST_PASS;
        end
      end
      ST_PASS: begin
        sel_ready        = m_axis_ready;
        m_axis_valid     = sel_valid;
        m_axis_data      = sel_data;
        m_axis_is_parity = sel_parity;
        m_axis_sop       = sel_valid & (cnt_q == '0);
        m_axis_last      = sel_valid & (at_max | sel_last);
        if (sel_valid && m_axis_ready) begin
          if (at_max || sel_last) begin
            if (grant_q) blk_cnt1_d = sat_inc16(blk_cnt1_q);
            else         blk_cnt0_d = sat_inc16(blk_cnt0_q);
            cnt_d = '0;
            // Source last wins; only a full-length block without source last is overlong.
            if (sel_last) begin
              state_d   = ST_IDLE;
              len_err_d = ~at_max;
            end else begin
              state_d   = ST_DRAIN;
              len_err_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        sel_ready = 1'b1;
        if (sel_valid && sel_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    s0_axis_ready = sel_ready & ~grant_q;
    s1_axis_ready = sel_ready & grant_q;
  end

  // last_grant resets to 1 so a tie straight after reset goes to source 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      blk_cnt0_q   <= 16'd0;
      blk_cnt1_q   <= 16'd0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      blk_cnt0_q   <= blk_cnt0_d;
      blk_cnt1_q   <= blk_cnt1_d;
      len_err_q    <= len_err_d;
    end
  end

  assign m_axis_src = grant_q;
  assign blk_cnt0   = blk_cnt0_q;
  assign blk_cnt1   = blk_cnt1_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_enc_block_arbiter.sv
// Directed bench for enc_block_arbiter: cycle table for routing/handshake detail,
// plus block-level sequences checked through a handshake scoreboard.
module tb_enc_block_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        s0_axis_valid, s0_axis_ready, s0_axis_last, s0_axis_is_parity;
  logic [7:0]  s0_axis_data;
  logic        s1_axis_valid, s1_axis_ready, s1_axis_last, s1_axis_is_parity;
  logic [7:0]  s1_axis_data;
  logic        m_axis_valid, m_axis_ready, m_axis_last, m_axis_sop, m_axis_is_parity;
  logic [7:0]  m_axis_data;
  logic        m_axis_src;
  logic [15:0] blk_cnt0, blk_cnt1;
  logic        len_err;

  always #5 clk = ~clk;

  enc_block_arbiter #(.BLOCK_LEN(255), .FIXED_PRIO(1'b0)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .s0_axis_valid     (s0_axis_valid),
    .s0_axis_ready     (s0_axis_ready),
    .s0_axis_data      (s0_axis_data),
    .s0_axis_last      (s0_axis_last),
    .s0_axis_is_parity (s0_axis_is_parity),
    .s1_axis_valid     (s1_axis_valid),
    .s1_axis_ready     (s1_axis_ready),
    .s1_axis_data      (s1_axis_data),
    .s1_axis_last      (s1_axis_last),
    .s1_axis_is_parity (s1_axis_is_parity),
    .m_axis_valid      (m_axis_valid),
    .m_axis_ready      (m_axis_ready),
    .m_axis_data       (m_axis_data),
    .m_axis_last       (m_axis_last),
    .m_axis_sop        (m_axis_sop),
    .m_axis_is_parity  (m_axis_is_parity),
    .m_axis_src        (m_axis_src),
    .blk_cnt0          (blk_cnt0),
    .blk_cnt1          (blk_cnt1),
    .len_err           (len_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       s;
    logic       p;
    logic       src;
    int         cyc;
  } rec_t;

  rec_t mq[$];
  int   cyc_cnt    = 0;
  int   drain_cnt  = 0;
  int   lerr_cnt   = 0;
  int   mirror_err = 0;

  // Scoreboard: record every output handshake, drained source beats and len_err pulses.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (m_axis_valid && m_axis_ready) begin
        r.d = m_axis_data; r.l = m_axis_last; r.s = m_axis_sop;
        r.p = m_axis_is_parity; r.src = m_axis_src; r.cyc = cyc_cnt;
        mq.push_back(r);
      end
      if (((s0_axis_valid && s0_axis_ready) || (s1_axis_valid && s1_axis_ready)) && !m_axis_valid)
        drain_cnt++;
      if (len_err) lerr_cnt++;
      if (m_axis_valid) begin
        if (m_axis_src ? (s1_axis_ready !== m_axis_ready || s0_axis_ready !== 1'b0)
                       : (s0_axis_ready !== m_axis_ready || s1_axis_ready !== 1'b0))
          mirror_err++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_src(input int src, input logic v, input logic [7:0] d, input logic l, input logic p);
    if (src == 0) begin
      s0_axis_valid = v; s0_axis_data = d; s0_axis_last = l; s0_axis_is_parity = p;
    end else begin
      s1_axis_valid = v; s1_axis_data = d; s1_axis_last = l; s1_axis_is_parity = p;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the final handshake.
  task automatic drive_block(input int src, input int n, input logic [7:0] base);
    int         waited;
    logic       hs;
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      set_src(src, 1'b1, b, (i == n - 1), b[0]);
      waited = 0;
      hs = 1'b0;
      while (!hs && waited < 3000) begin
        @(negedge clk);
        hs = (src == 0) ? s0_axis_ready : s1_axis_ready;
        if (!hs) begin
          @(posedge clk); #1;
        end
        waited++;
      end
      if (!hs) begin
        n_checks++; n_fail++;
        $display("FAIL src%0d_handshake_timeout: byte %0d got no ready, required ready", src, i);
        set_src(src, 1'b0, 8'h00, 1'b0, 1'b0);
        return;
      end
      @(posedge clk); #1;
    end
    set_src(src, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_block(input string name, input int start, input int n,
                             input logic src, input logic [7:0] base);
    logic [7:0] ed;
    int         bad;
    n_checks++;
    if (mq.size() < start + n) begin
      n_fail++;
      $display("FAIL %s: got %0d output beats, required at least %0d", name, mq.size(), start + n);
      return;
    end
    bad = -1;
    for (int i = 0; i < n; i++) begin
      ed = base + 8'(i);
      if (mq[start+i].d !== ed || mq[start+i].s !== (i == 0) || mq[start+i].l !== (i == n - 1) ||
          mq[start+i].src !== src || mq[start+i].p !== ed[0]) begin
        bad = i;
        break;
      end
    end
    if (bad >= 0) begin
      ed = base + 8'(bad);
      n_fail++;
      $display("FAIL %s: beat %0d got d=%02h sop=%0b last=%0b par=%0b src=%0b required d=%02h sop=%0b last=%0b par=%0b src=%0b",
               name, bad, mq[start+bad].d, mq[start+bad].s, mq[start+bad].l, mq[start+bad].p,
               mq[start+bad].src, ed, (bad == 0), (bad == n - 1), ed[0], src);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    enable = 1'b0;
    set_src(0, 1'b0, 8'h00, 1'b0, 1'b0);
    set_src(1, 1'b0, 8'h00, 1'b0, 1'b0);
    m_axis_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    drain_cnt = 0;
    lerr_cnt = 0;
    mirror_err = 0;
  endtask

  function automatic logic [63:0] out_vec();
    return {15'd0, m_axis_valid, m_axis_data, m_axis_last, m_axis_sop, m_axis_is_parity,
            m_axis_src, s0_axis_ready, s1_axis_ready, len_err, blk_cnt0, blk_cnt1};
  endfunction

  typedef struct {
    logic en;
    logic s0v; logic [7:0] s0d; logic s0l; logic s0p;
    logic s1v; logic [7:0] s1d; logic s1l; logic s1p;
    logic rdy;
    logic mv; logic [7:0] md; logic ml; logic sop; logic mpar;
    logic msrc; logic s0r; logic s1r; logic le;
    logic [15:0] b0; logic [15:0] b1;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  initial begin
    logic [63:0] act, exp;
    bit          done;
    int          w;

    // en  s0: v d l p              s1: v d l p               rdy | mv md ml sop par src s0r s1r le b0 b1
    vecs[0]  = '{1'b1, 1'b0,8'h00,1'b0,1'b0, 1'b1,8'hA0,1'b0,1'b1, 1'b1, 1'b0,8'h00,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 16'd0,16'd0};
    vecs[1]  = '{1'b1, 1'b0,8'h00,1'b0,1'b0, 1'b1,8'hA0,1'b0,1'b1, 1'b1, 1'b1,8'hA0,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b0, 16'd0,16'd0};
    vecs[2]  = '{1'b1, 1'b0,8'h00,1'b0,1'b0, 1'b1,8'hA1,1'b0,1'b0, 1'b0, 1'b1,8'hA1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 16'd0,16'd0};
    vecs[3]  = '{1'b1, 1'b1,8'h55,1'b0,1'b0, 1'b1,8'hA1,1'b0,1'b0, 1'b1, 1'b1,8'hA1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 16'd0,16'd0};
    vecs[4]  = '{1'b1, 1'b1,8'h55,1'b0,1'b0, 1'b0,8'h00,1'b0,1'b0, 1'b1, 1'b0,8'h00,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 16'd0,16'd0};
    vecs[5]  = '{1'b1, 1'b1,8'h55,1'b1,1'b0, 1'b1,8'hA2,1'b1,1'b1, 1'b1, 1'b1,8'hA2,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0, 16'd0,16'd0};
    vecs[6]  = '{1'b1, 1'b1,8'h55,1'b1,1'b0, 1'b1,8'hB0,1'b0,1'b0, 1'b1, 1'b0,8'h00,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1, 16'd0,16'd1};
    vecs[7]  = '{1'b1, 1'b1,8'h55,1'b1,1'b0, 1'b1,8'hB0,1'b0,1'b0, 1'b1, 1'b1,8'h55,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0, 16'd0,16'd1};
    vecs[8]  = '{1'b0, 1'b0,8'h00,1'b0,1'b0, 1'b1,8'hB0,1'b0,1'b0, 1'b1, 1'b0,8'h00,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1, 16'd1,16'd1};
    vecs[9]  = '{1'b0, 1'b0,8'h00,1'b0,1'b0, 1'b1,8'hB0,1'b0,1'b0, 1'b1, 1'b0,8'h00,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 16'd1,16'd1};
    vecs[10] = '{1'b1, 1'b0,8'h00,1'b0,1'b0, 1'b1,8'hB0,1'b0,1'b0, 1'b1, 1'b0,8'h00,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 16'd1,16'd1};
    vecs[11] = '{1'b1, 1'b0,8'h00,1'b0,1'b0, 1'b1,8'hB0,1'b0,1'b0, 1'b1, 1'b1,8'hB0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0, 16'd1,16'd1};
    vecs[12] = '{1'b0, 1'b0,8'h00,1'b0,1'b0, 1'b1,8'hB1,1'b1,1'b1, 1'b1, 1'b1,8'hB1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0, 16'd1,16'd1};
    vecs[13] = '{1'b0, 1'b0,8'h00,1'b0,1'b0, 1'b0,8'h00,1'b0,1'b0, 1'b1, 1'b0,8'h00,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1, 16'd1,16'd2};

    // Reset held from time zero with every input pushing for activity.
    rst_n = 1'b0;
    enable = 1'b1;
    set_src(0, 1'b1, 8'hFF, 1'b1, 1'b1);
    set_src(1, 1'b1, 8'hFF, 1'b1, 1'b1);
    m_axis_ready = 1'b1;
    @(negedge clk);
    check("reset_outputs", out_vec(), 64'd0);

    // Cycle table
    do_reset();
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      enable = vecs[i].en;
      set_src(0, vecs[i].s0v, vecs[i].s0d, vecs[i].s0l, vecs[i].s0p);
      set_src(1, vecs[i].s1v, vecs[i].s1d, vecs[i].s1l, vecs[i].s1p);
      m_axis_ready = vecs[i].rdy;
      @(negedge clk);
      act = out_vec();
      if (!vecs[i].mv) act[46:36] = 11'd0;
      exp = {15'd0, vecs[i].mv, vecs[i].md, vecs[i].ml, vecs[i].sop, vecs[i].mpar, vecs[i].msrc,
             vecs[i].s0r, vecs[i].s1r, vecs[i].le, vecs[i].b0, vecs[i].b1};
      check($sformatf("vec%0d", i), act, exp);
    end

    // Single full block from source 0
    do_reset();
    enable = 1'b1;
    drive_block(0, 255, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check_block("single_s0", 0, 255, 1'b0, 8'h00);
    check("single_beats", 64'(mq.size()), 64'd255);
    check("single_blk_cnt0", 64'(blk_cnt0), 64'd1);
    check("single_len_err", 64'(lerr_cnt), 64'd0);

    // Contention, round-robin
    do_reset();
    enable = 1'b1;
    fork
      begin drive_block(0, 255, 8'h00); drive_block(0, 255, 8'h40); end
      begin drive_block(1, 255, 8'h80); drive_block(1, 255, 8'hC0); end
    join
    repeat (3) @(posedge clk);
    #1;
    check_block("rr_blk0_s0", 0,   255, 1'b0, 8'h00);
    check_block("rr_blk1_s1", 255, 255, 1'b1, 8'h80);
    check_block("rr_blk2_s0", 510, 255, 1'b0, 8'h40);
    check_block("rr_blk3_s1", 765, 255, 1'b1, 8'hC0);
    if (mq.size() >= 1020) begin
      for (int b = 1; b < 4; b++)
        check($sformatf("rr_gap%0d_cycles", b), 64'(mq[b*255].cyc - mq[b*255-1].cyc), 64'd2);
    end
    check("rr_blk_cnts", {32'd0, blk_cnt0, blk_cnt1}, {32'd0, 16'd2, 16'd2});
    check("rr_len_err", 64'(lerr_cnt), 64'd0);

    // Short block from source 1, then a normal block from source 0
    do_reset();
    enable = 1'b1;
    drive_block(1, 100, 8'h20);
    drive_block(0, 255, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check_block("short_s1", 0, 100, 1'b1, 8'h20);
    check_block("after_short_s0", 100, 255, 1'b0, 8'h00);
    check("short_len_err", 64'(lerr_cnt), 64'd1);
    check("short_blk_cnts", {32'd0, blk_cnt0, blk_cnt1}, {32'd0, 16'd1, 16'd1});

    // Overlong block: 300 bytes against a 255-byte block
    do_reset();
    enable = 1'b1;
    drive_block(0, 300, 8'h00);
    @(negedge clk);
    check("overlong_back_idle", {61'd0, m_axis_valid, s0_axis_ready, s1_axis_ready}, 64'd0);
    check_block("overlong_s0", 0, 255, 1'b0, 8'h00);
    check("overlong_beats", 64'(mq.size()), 64'd255);
    check("overlong_drained", 64'(drain_cnt), 64'd45);
    check("overlong_len_err", 64'(lerr_cnt), 64'd1);
    check("overlong_blk_cnt0", 64'(blk_cnt0), 64'd1);

    // Random backpressure
    do_reset();
    enable = 1'b1;
    done = 1'b0;
    fork
      begin drive_block(0, 255, 8'h33); done = 1'b1; end
      begin
        while (!done) begin
          @(posedge clk); #1;
          m_axis_ready = 1'($urandom_range(0, 1));
        end
        m_axis_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check_block("bp_s0", 0, 255, 1'b0, 8'h33);
    check("bp_ready_mirror", 64'(mirror_err), 64'd0);

    // Reset in the middle of a block, then grant gated by enable
    do_reset();
    enable = 1'b1;
    set_src(0, 1'b1, 8'h5A, 1'b0, 1'b0);
    w = 0;
    while (mq.size() < 50 && w < 300) begin
      @(posedge clk);
      w++;
    end
    check("midblk_beats_before_reset", 64'(mq.size()), 64'd50);
    #1;
    rst_n = 1'b0;
    set_src(1, 1'b1, 8'hA5, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("midblk_reset_outputs%0d", c), out_vec(), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    enable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("no_grant_disabled%0d", c),
            {60'd0, m_axis_valid, s0_axis_ready, s1_axis_ready, m_axis_src}, 64'd0);
      @(posedge clk); #1;
    end
    enable = 1'b1;
    @(negedge clk);
    check("enable_cycle_still_idle", {63'd0, m_axis_valid}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("first_beat_after_reset", {52'd0, m_axis_valid, m_axis_sop, m_axis_src, m_axis_last, m_axis_data},
          {52'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
